uart_frame_tx: RTL and testbench

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_frame_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx
// Purpose  : Periodic / on-demand 8N1 UART framer: [header] payload [checksum]
// Revision : 1.0
// ============================================================================
module uart_frame_tx #(
  parameter int         CLK_FREQ      = 100_000_000,
  parameter int         UART_BPS      = 115200,
  parameter int         NBYTES        = 8,
  parameter int         PERIOD_CYCLES = 10_000_000,
  parameter int         HDR_EN        = 1,
  parameter logic [7:0] HDR_BYTE      = 8'hA5,
  parameter int         CSUM_EN       = 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                auto_en,
  input  logic                trig,
  input  logic [8*NBYTES-1:0] din,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          drop_cnt,
  output logic                uart_txd
);

  localparam int c_baud_div = CLK_FREQ / UART_BPS;
  localparam int c_bw       = (c_baud_div > 1) ? $clog2(c_baud_div) : 1;
  localparam int c_pw       = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int c_hdr      = (HDR_EN != 0) ? 1 : 0;
  localparam int c_csum     = (CSUM_EN != 0) ? 1 : 0;
  localparam int c_total    = NBYTES + c_hdr + c_csum;

  localparam logic [c_bw-1:0] c_baud_last   = c_bw'(c_baud_div - 1);
  localparam logic [c_pw-1:0] c_period_last = c_pw'(PERIOD_CYCLES - 1);
  localparam logic [4:0]      c_last_byte   = 5'(c_total - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              r_state, w_state_nx;
  logic [c_bw-1:0]     r_baud_cnt, w_baud_nx;
  logic [2:0]          r_bit_idx, w_bit_nx, w_bit_inc;
  logic [4:0]          r_byte_idx, w_byte_nx;
  logic [8*NBYTES-1:0] r_data, w_data_nx;
  logic                r_pending, w_pend_nx;
  logic                r_txd, w_txd_nx;
  logic                r_frame_done, w_done_nx;
  logic [7:0]          r_drop_cnt;
  logic [c_pw-1:0]     r_period_cnt;
  logic                w_tick, w_req, w_baud_end, w_frame_end, w_launch, w_drop_inc;
  logic [7:0]          w_csum, w_cur_byte;

  // Free-running period counter; auto_en only gates the tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                       r_period_cnt <= '0;
    else if (r_period_cnt == c_period_last) r_period_cnt <= '0;
    else                                  r_period_cnt <= r_period_cnt + c_pw'(1);
  end

  assign w_tick = (r_period_cnt == c_period_last) && auto_en;
  assign w_req  = w_tick || trig;

  always_comb begin
    w_csum = 8'h00;
    for (int i = 0; i < NBYTES; i++) w_csum = w_csum + r_data[8*i +: 8];
  end

  // Byte 0 is the header when enabled; the slot after the payload is the checksum.
  always_comb begin
    w_cur_byte = w_csum;
    for (int i = 0; i < NBYTES; i++)
      if (r_byte_idx == 5'(i + c_hdr)) w_cur_byte = r_data[8*(NBYTES-1-i) +: 8];
    if (c_hdr != 0 && r_byte_idx == 5'd0) w_cur_byte = HDR_BYTE;
  end

  assign w_bit_inc   = r_bit_idx + 3'd1;
  assign w_baud_end  = (r_baud_cnt == c_baud_last);
  assign w_frame_end = (r_state == S_STOP) && w_baud_end && (r_byte_idx == c_last_byte);

  always_comb begin
    w_state_nx = r_state;
    w_baud_nx  = r_baud_cnt;
    w_bit_nx   = r_bit_idx;
    w_byte_nx  = r_byte_idx;
    w_data_nx  = r_data;
    w_pend_nx  = r_pending;
    w_txd_nx   = r_txd;
    w_done_nx  = 1'b0;
    w_launch   = 1'b0;
    w_drop_inc = 1'b0;

    case (r_state)
      S_IDLE: w_launch = w_req;
      S_START: begin
        if (w_baud_end) begin
          w_state_nx = S_DATA;
          w_baud_nx  = '0;
          w_bit_nx   = 3'd0;
          w_txd_nx   = w_cur_byte[0];
        end else begin
          w_baud_nx = r_baud_cnt + c_bw'(1);
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nx = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nx = S_STOP;
            w_txd_nx   = 1'b1;
          end else begin
            w_bit_nx = w_bit_inc;
            w_txd_nx = w_cur_byte[w_bit_inc];
          end
        end else begin
          w_baud_nx = r_baud_cnt + c_bw'(1);
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nx = '0;
          if (w_frame_end) begin
            // A request landing in the final cycle acts as pending and launches at once.
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
            w_txd_nx   = 1'b1;
            w_launch   = r_pending | w_req;
            w_drop_inc = r_pending & w_req;
          end else begin
            w_byte_nx  = r_byte_idx + 5'd1;
            w_state_nx = S_START;
            w_txd_nx   = 1'b0;
          end
        end else begin
          w_baud_nx = r_baud_cnt + c_bw'(1);
        end
      end
      default: w_state_nx = S_IDLE;
    endcase

    if (r_state != S_IDLE && !w_frame_end && w_req) begin
      if (r_pending) w_drop_inc = 1'b1;
      else           w_pend_nx  = 1'b1;
    end

    if (w_launch) begin
      w_state_nx = S_START;
      w_baud_nx  = '0;
      w_bit_nx   = 3'd0;
      w_byte_nx  = 5'd0;
      w_data_nx  = din;
      w_txd_nx   = 1'b0;
      w_pend_nx  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_idx    <= 3'd0;
      r_byte_idx   <= 5'd0;
      r_data       <= '0;
      r_pending    <= 1'b0;
      r_txd        <= 1'b1;
      r_frame_done <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nx;
      r_baud_cnt   <= w_baud_nx;
      r_bit_idx    <= w_bit_nx;
      r_byte_idx   <= w_byte_nx;
      r_data       <= w_data_nx;
      r_pending    <= w_pend_nx;
      r_txd        <= w_txd_nx;
      r_frame_done <= w_done_nx;
      if (w_drop_inc && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_frame_done;
  assign drop_cnt   = r_drop_cnt;
  assign uart_txd   = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_tx.sv
`default_nettype none
// Bench for uart_frame_tx: a 2-byte framed instance decoded to a byte
// scoreboard, and a bare 1-byte instance checked bit by bit.
module tb_uart_frame_tx;
  localparam int BAUD = 10;
  localparam int PER  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic auto_en, trig;
  logic [15:0] din;
  logic busy, frame_done, txd;
  logic [7:0] drop_cnt;
  logic auto_en1, trig1;
  logic [7:0] din1;
  logic busy1, done1, txd1;
  logic [7:0] drop1;

  int n_tests = 0;
  int n_fail  = 0;
  int stop_err = 0;
  int pm = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_frame_tx #(
    .CLK_FREQ(1_000_000), .UART_BPS(100_000), .NBYTES(2), .PERIOD_CYCLES(PER),
    .HDR_EN(1), .HDR_BYTE(8'hA5), .CSUM_EN(1)
  ) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .auto_en(auto_en), .trig(trig), .din(din),
    .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt), .uart_txd(txd)
  );

  uart_frame_tx #(
    .CLK_FREQ(1_000_000), .UART_BPS(100_000), .NBYTES(1), .PERIOD_CYCLES(PER),
    .HDR_EN(0), .HDR_BYTE(8'hA5), .CSUM_EN(0)
  ) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .auto_en(auto_en1), .trig(trig1), .din(din1),
    .busy(busy1), .frame_done(done1), .drop_cnt(drop1), .uart_txd(txd1)
  );

  // Reference period counter: value during the current cycle.
  initial forever begin
    @(posedge clk);
    if (!rst_n) pm = 0;
    else        pm = (pm == PER-1) ? 0 : pm + 1;
  end

  // 8N1 receiver on the framed instance, sampling mid-bit.
  initial begin : g_monitor
    bit act;
    int k;
    logic [7:0] sh;
    act = 0; k = 0; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) act = 0;
      else if (!act) begin
        if (txd === 1'b0) begin act = 1; k = 0; end
      end else begin
        k++;
        if (k % BAUD == BAUD/2) begin
          if (k/BAUD >= 1 && k/BAUD <= 8) sh[k/BAUD - 1] = txd;
          else if (k/BAUD == 9) begin
            if (txd !== 1'b1) stop_err++;
            rx_q.push_back(sh);
            act = 0;
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [15:0] d);
    logic [7:0] s;
    s = d[15:8] + d[7:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(s);
  endtask

  task automatic launch(input logic [15:0] d);
    @(posedge clk); #1; din = d; trig = 1'b1;
    @(posedge clk); #1; trig = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async: txd=%b busy=%b done=%b drop=%0d, required 1 0 0 0", txd, busy, frame_done, drop_cnt);
    end
    n_tests++;
    if (txd1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || drop1 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_async_1: txd=%b busy=%b done=%b drop=%0d, required 1 0 0 0", txd1, busy1, done1, drop1);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_tests++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: txd=%b busy=%b, required 1 0", txd, busy);
    end
  endtask

  task automatic test_single;
    int busy_cnt, dones, done_at;
    logic [7:0] gv, ev;
    exp_q.delete(); rx_q.delete(); stop_err = 0;
    busy_cnt = 0; dones = 0; done_at = -1;
    push_frame(16'h1234);
    launch(16'h1234);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_tests++;
        if (busy !== 1'b1 || txd !== 1'b0) begin
          n_fail++;
          $display("FAIL single_start: busy=%b txd=%b, required 1 0", busy, txd);
        end
      end
      if (busy === 1'b1) busy_cnt++;
      if (frame_done === 1'b1) begin dones++; done_at = c; end
    end
    n_tests++;
    if (busy_cnt != 400) begin n_fail++; $display("FAIL single_busy_len: got %0d, required 400", busy_cnt); end
    n_tests++;
    if (dones != 1 || done_at != 400) begin
      n_fail++;
      $display("FAIL single_done: pulses=%0d at=%0d, required 1 at 400", dones, done_at);
    end
    n_tests++;
    if (rx_q.size() != exp_q.size() || stop_err != 0) begin
      n_fail++;
      $display("FAIL single_nbytes: got %0d bytes (%0d stop errs), required %0d", rx_q.size(), stop_err, exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      gv = rx_q.pop_front(); ev = exp_q.pop_front();
      n_tests++;
      if (gv !== ev) begin n_fail++; $display("FAIL single_byte: got %02h, required %02h", gv, ev); end
    end
  endtask

  task automatic test_same_tick;
    bit found;
    int busy_cnt, dones;
    logic [7:0] gv, ev;
    exp_q.delete(); rx_q.delete(); stop_err = 0;
    found = 0; busy_cnt = 0; dones = 0;
    for (int c = 0; c < 1100 && !found; c++) begin
      @(negedge clk);
      if (pm == PER-1) found = 1;
    end
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL tick_align: counter end not seen, got 0 required 1"); end
    din = 16'h00FF; auto_en = 1'b1; trig = 1'b1;
    push_frame(16'h00FF);
    @(posedge clk); #1; auto_en = 1'b0; trig = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (frame_done === 1'b1) dones++;
    end
    n_tests++;
    if (busy_cnt != 400 || dones != 1) begin
      n_fail++;
      $display("FAIL same_tick_frames: busy=%0d done=%0d, required 400 1", busy_cnt, dones);
    end
    n_tests++;
    if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL same_tick_drop: got %0d, required 0", drop_cnt); end
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL same_tick_nbytes: got %0d, required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      gv = rx_q.pop_front(); ev = exp_q.pop_front();
      n_tests++;
      if (gv !== ev) begin n_fail++; $display("FAIL same_tick_byte: got %02h, required %02h", gv, ev); end
    end
  endtask

  task automatic test_auto;
    int st[$];
    logic prev_busy;
    logic [7:0] gv, ev;
    exp_q.delete(); rx_q.delete(); stop_err = 0;
    din = 16'hBEEF;
    prev_busy = busy;
    auto_en = 1'b1;
    for (int c = 0; c < 2600; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && prev_busy === 1'b0) begin
        st.push_back(c);
        push_frame(16'hBEEF);
        n_tests++;
        if (pm != 0) begin n_fail++; $display("FAIL auto_phase: start with counter %0d, required 0", pm); end
      end
      prev_busy = busy;
    end
    auto_en = 1'b0;
    repeat (500) @(negedge clk);
    n_tests++;
    if (st.size() < 2) begin n_fail++; $display("FAIL auto_count: got %0d frames, required >=2", st.size()); end
    for (int i = 1; i < st.size(); i++) begin
      n_tests++;
      if (st[i] - st[i-1] != PER) begin
        n_fail++;
        $display("FAIL auto_spacing: got %0d, required %0d", st[i] - st[i-1], PER);
      end
    end
    n_tests++;
    if (rx_q.size() != exp_q.size() || stop_err != 0) begin
      n_fail++;
      $display("FAIL auto_nbytes: got %0d (%0d stop errs), required %0d", rx_q.size(), stop_err, exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      gv = rx_q.pop_front(); ev = exp_q.pop_front();
      n_tests++;
      if (gv !== ev) begin n_fail++; $display("FAIL auto_byte: got %02h, required %02h", gv, ev); end
    end
  endtask

  task automatic test_back_to_back;
    int busy_cnt, dones, done_at;
    logic busy_at, txd_at;
    logic [7:0] gv, ev;
    exp_q.delete(); rx_q.delete(); stop_err = 0;
    busy_cnt = 0; dones = 0; done_at = -1; busy_at = 1'bx; txd_at = 1'bx;
    push_frame(16'h1234);
    push_frame(16'hC35A);
    launch(16'h1234);
    fork
      begin
        repeat (50) @(posedge clk); #1; trig = 1'b1;
        @(posedge clk); #1; trig = 1'b0;
        repeat (9) @(posedge clk); #1; trig = 1'b1;
        @(posedge clk); #1; trig = 1'b0;
        repeat (139) @(posedge clk); #1; din = 16'hC35A;
      end
      begin
        for (int c = 0; c < 1000; c++) begin
          @(negedge clk);
          if (busy === 1'b1) busy_cnt++;
          if (frame_done === 1'b1) begin
            dones++;
            if (dones == 1) begin done_at = c; busy_at = busy; txd_at = txd; end
          end
        end
      end
    join
    n_tests++;
    if (busy_cnt != 800 || dones != 2) begin
      n_fail++;
      $display("FAIL b2b_len: busy=%0d done=%0d, required 800 2", busy_cnt, dones);
    end
    n_tests++;
    if (done_at != 400 || busy_at !== 1'b1 || txd_at !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_handover: at=%0d busy=%b txd=%b, required 400 1 0", done_at, busy_at, txd_at);
    end
    n_tests++;
    if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_drop: got %0d, required 1", drop_cnt); end
    n_tests++;
    if (rx_q.size() != exp_q.size() || stop_err != 0) begin
      n_fail++;
      $display("FAIL b2b_nbytes: got %0d (%0d stop errs), required %0d", rx_q.size(), stop_err, exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      gv = rx_q.pop_front(); ev = exp_q.pop_front();
      n_tests++;
      if (gv !== ev) begin n_fail++; $display("FAIL b2b_byte: got %02h, required %02h", gv, ev); end
    end
  endtask

  task automatic test_mid_reset;
    int activity;
    logic [7:0] gv, ev;
    exp_q.delete(); rx_q.delete(); stop_err = 0;
    activity = 0;
    exp_q.push_back(8'hA5);
    launch(16'h1234);
    repeat (137) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_abort: txd=%b busy=%b done=%b, required 1 0 0", txd, busy, frame_done);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || txd !== 1'b1 || frame_done !== 1'b0) activity++;
    end
    n_tests++;
    if (activity != 0) begin n_fail++; $display("FAIL midrst_quiet: %0d active cycles, required 0", activity); end
    n_tests++;
    if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_drop: got %0d, required 0", drop_cnt); end
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_nbytes: got %0d, required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      gv = rx_q.pop_front(); ev = exp_q.pop_front();
      n_tests++;
      if (gv !== ev) begin n_fail++; $display("FAIL midrst_byte: got %02h, required %02h", gv, ev); end
    end
  endtask

  task automatic test_bits80;
    logic bit_q[$];
    logic b;
    int busy_cnt, dones, done_at;
    busy_cnt = 0; dones = 0; done_at = -1;
    for (int i = 0; i < 8; i++) bit_q.push_back(1'b0);
    bit_q.push_back(1'b1);
    bit_q.push_back(1'b1);
    @(posedge clk); #1; din1 = 8'h80; trig1 = 1'b1;
    @(posedge clk); #1; trig1 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (c % BAUD == BAUD/2 && c / BAUD < 10) begin
        b = bit_q.pop_front();
        n_tests++;
        if (txd1 !== b) begin n_fail++; $display("FAIL bits80_bit%0d: got %b, required %b", c / BAUD, txd1, b); end
      end
      if (busy1 === 1'b1) busy_cnt++;
      if (done1 === 1'b1) begin dones++; done_at = c; end
    end
    n_tests++;
    if (busy_cnt != 100 || dones != 1 || done_at != 100) begin
      n_fail++;
      $display("FAIL bits80_len: busy=%0d done=%0d at=%0d, required 100 1 100", busy_cnt, dones, done_at);
    end
  endtask

  initial begin
    auto_en = 1'b0; trig = 1'b0; din = 16'h0000;
    auto_en1 = 1'b0; trig1 = 1'b0; din1 = 8'h00;
    test_reset();
    test_single();
    test_same_tick();
    test_auto();
    test_back_to_back();
    test_mid_reset();
    test_bits80();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
